ahb_cmd_master: RTL and testbench
=================================

// Module: ahb_cmd_master
// PURPOSE
// AHB-Lite initiator for the verification environment. Converts single-transfer
// commands (valid/ready) into pipelined AHB NONSEQ SINGLE transfers and returns
// one in-order response per command. Drives SRAM/peripheral responder models
// through the bus fabric, including wait states and two-cycle ERROR responses.
// PARAMETERS
// ADDR_WIDTH   32          haddr/cmd_addr width
// DATA_WIDTH   32          hwdata/hrdata/cmd_wdata width
// MASTER_ID    4'h0        constant value driven on hmaster
// HPROT        7'b0000011  constant value driven on hprot
// TIMEOUT_CYC  16384       wait-state limit (AHB_MST_TIMEOUT_EN only)
// PORTS
// clk         in   1           clock
// rstn        in   1           async reset, active low
// cmd_valid   in   1           command present
// cmd_ready   out  1           command accepted when valid&ready at posedge
// cmd_write   in   1           1=write, 0=read
// cmd_addr    in   ADDR_WIDTH  byte address, caller aligns to cmd_size
// cmd_size    in   3           0=byte 1=half 2=word; >2 illegal
// cmd_wdata   in   DATA_WIDTH  write data, lanes pre-placed by caller
// rsp_valid   out  1           one-cycle pulse per retired command, no backpressure
// rsp_rdata   out  DATA_WIDTH  read data (0 for writes/errors)
// rsp_err     out  1           transfer got ERROR or was cancelled
// haddr,hwrite,hsize,hburst,htrans,hwdata  out  AHB address/data phase signals
// hprot[6:0],hnonsec,hmaster[3:0],hexcl    out  constant attributes
// hready      in   1           bus ready (responder hreadyout)
// hresp       in   1           0=OKAY 1=ERROR
// hrdata      in   DATA_WIDTH  read data
// hexokay     in   1           ignored
// timeout     out  1           sticky wait-state timeout flag
// BEHAVIOUR
// - Reset: htrans=IDLE, haddr/hwrite/hsize/hwdata=0, hburst=0 (SINGLE), hexcl=0,
//   hnonsec=0, hprot=HPROT, hmaster=MASTER_ID, rsp_*=0, cmd_ready=0, timeout=0.
//   Reset mid-transfer drops all in-flight commands; no responses issued.
// - Two slots: AP (address phase) and DP (data phase). Each slot holds write,
//   addr, size, wdata.
// - cmd_ready = !err_state && (!ap_valid || hready). Accepted cmd loads AP;
//   htrans=NONSEQ from next cycle. No accept -> htrans=IDLE once AP advances.
// - AP advances to DP at posedge with hready=1; hwdata driven from DP slot next
//   cycle and held stable while hready=0. Back-to-back: new AP overlaps DP.
// - DP retires at posedge with hready=1: next cycle rsp_valid=1,
//   rsp_rdata=hrdata if read & OKAY else 0, rsp_err=hresp. Latency accept->rsp
//   = 3 cycles with zero wait states.
// - Error FSM: OK -> ERR1 on DP_valid & hready=0 & hresp=1. In ERR1 cycle
//   (2nd error cycle) htrans forced IDLE, pending AP transfer cancelled,
//   cmd_ready=0. ERR1 -> OK on hready=1: errored transfer retires (rsp_err=1);
//   cancelled AP transfer, if any, retires next cycle with rsp_err=1, rdata=0.
//   Responses remain strictly in command order.
// - hresp=1 with hready=1 and no prior ERR1 cycle: retire with rsp_err=1.
// - cmd_size>2 or misaligned addr: simulation $error at accept; bus behaviour
//   unspecified.
// - hsize/haddr/hwrite stable while htrans=NONSEQ and hready=0.
// CONFIGURATION
// AHB_MST_TIMEOUT_EN defined: counter of consecutive cycles DP_valid & hready=0;
//   reaching TIMEOUT_CYC sets timeout=1 (sticky until reset), $error printed
//   once with haddr of DP transfer; bus state unchanged.
// Not defined: no counter; timeout tied 0.
// TESTING
// 1 write 0x100=0xDEADBEEF, read 0x100, zero waits -> rsp pulses 3 and 4 cycles
//   after accepts, second rsp_rdata=0xDEADBEEF, rsp_err=0.
// 2 4 back-to-back reads, cmd_valid held -> htrans NONSEQ 4 consecutive cycles,
//   4 consecutive rsp pulses in order.
// 3 write with 3 wait states -> hwdata stable 4 cycles, next AP held,
//   rsp after hready rises, rsp_err=0.
// 4 read 0x200 ERROR while read 0x204 in AP -> htrans IDLE in 2nd error cycle,
//   two rsp pulses both rsp_err=1, rdata=0; next cmd then completes OKAY.
// 5 assert rstn=0 during wait state -> all outputs reset values, no rsp_valid;
//   fresh command after reset completes normally.
// 6 (AHB_MST_TIMEOUT_EN, TIMEOUT_CYC=8) hready low 8 cycles -> timeout=1, stays 1.

Source files
------------

// File: rtl/ahb_cmd_master.sv
// AHB-Lite single-transfer initiator: valid/ready commands in, NONSEQ SINGLE
// transfers on the bus, one in-order response per command. Optional macro: AHB_MST_TIMEOUT_EN.
module ahb_cmd_master #(
    parameter int         ADDR_WIDTH  = 32,
    parameter int         DATA_WIDTH  = 32,
    parameter logic [3:0] MASTER_ID   = 4'h0,
    parameter logic [6:0] HPROT       = 7'b0000011,
    parameter int         TIMEOUT_CYC = 16384
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [2:0]            cmd_size,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] haddr,
    output logic                  hwrite,
    output logic [2:0]            hsize,
    output logic [2:0]            hburst,
    output logic [1:0]            htrans,
    output logic [DATA_WIDTH-1:0] hwdata,
    output logic [6:0]            hprot,
    output logic                  hnonsec,
    output logic [3:0]            hmaster,
    output logic                  hexcl,
    input  logic                  hready,
    input  logic                  hresp,
    input  logic [DATA_WIDTH-1:0] hrdata,
    input  logic                  hexokay,
    output logic                  timeout
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic {
        ST_OK   = 1'b0,
        ST_ERR1 = 1'b1
    } err_state_t;

    err_state_t            state_reg;
    logic                  run_reg;
    logic                  ap_valid_reg;
    logic                  ap_write_reg;
    logic [ADDR_WIDTH-1:0] ap_addr_reg;
    logic [2:0]            ap_size_reg;
    logic [DATA_WIDTH-1:0] ap_wdata_reg;
    logic                  dp_valid_reg;
    logic                  dp_write_reg;
    logic [DATA_WIDTH-1:0] dp_wdata_reg;
    logic [1:0]            htrans_reg;
    logic                  cancel_reg;
    logic                  rsp_valid_reg;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg;
    logic                  rsp_err_reg;

    logic accept;
    logic ap_adv;
    logic dp_ret;
    logic err_enter;
    logic unused_hexokay;

    assign unused_hexokay = hexokay;

    assign cmd_ready = run_reg && (state_reg == ST_OK) && (!ap_valid_reg || hready);
    assign accept    = cmd_valid && cmd_ready;
    assign ap_adv    = ap_valid_reg && hready && (state_reg == ST_OK);
    assign dp_ret    = dp_valid_reg && hready;
    // First cycle of a two-cycle ERROR response seen on the data phase
    assign err_enter = (state_reg == ST_OK) && dp_valid_reg && !hready && hresp;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= ST_OK;
            run_reg       <= 1'b0;
            ap_valid_reg  <= 1'b0;
            ap_write_reg  <= 1'b0;
            ap_addr_reg   <= '0;
            ap_size_reg   <= '0;
            ap_wdata_reg  <= '0;
            dp_valid_reg  <= 1'b0;
            dp_write_reg  <= 1'b0;
            dp_wdata_reg  <= '0;
            htrans_reg    <= HTRANS_IDLE;
            cancel_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            run_reg       <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;

            // Response: data-phase retirement first, a cancelled AP command after it
            if (dp_ret) begin
                rsp_valid_reg <= 1'b1;
                rsp_err_reg   <= hresp || (state_reg == ST_ERR1);
                if (!dp_write_reg && !hresp && (state_reg == ST_OK))
                    rsp_rdata_reg <= hrdata;
            end else if (cancel_reg && (state_reg == ST_OK)) begin
                rsp_valid_reg <= 1'b1;
                rsp_err_reg   <= 1'b1;
                cancel_reg    <= 1'b0;
            end

            if (ap_adv) begin
                dp_valid_reg <= 1'b1;
                dp_write_reg <= ap_write_reg;
                dp_wdata_reg <= ap_wdata_reg;
            end else if (dp_ret) begin
                dp_valid_reg <= 1'b0;
            end

            // A command accepted on the error edge never reaches the bus either
            if (err_enter) begin
                ap_valid_reg <= 1'b0;
                htrans_reg   <= HTRANS_IDLE;
                cancel_reg   <= ap_valid_reg || accept;
            end else if (accept) begin
                ap_valid_reg <= 1'b1;
                ap_write_reg <= cmd_write;
                ap_addr_reg  <= cmd_addr;
                ap_size_reg  <= cmd_size;
                ap_wdata_reg <= cmd_write ? cmd_wdata : '0;
                htrans_reg   <= HTRANS_NONSEQ;
            end else if (ap_adv) begin
                ap_valid_reg <= 1'b0;
                htrans_reg   <= HTRANS_IDLE;
            end

            case (state_reg)
                ST_OK:   if (err_enter) state_reg <= ST_ERR1;
                ST_ERR1: if (hready) state_reg <= ST_OK;
                default: state_reg <= ST_OK;
            endcase
        end
    end

    assign haddr     = ap_addr_reg;
    assign hwrite    = ap_write_reg;
    assign hsize     = ap_size_reg;
    assign htrans    = htrans_reg;
    assign hwdata    = dp_wdata_reg;
    assign hburst    = 3'b000;
    assign hprot     = HPROT;
    assign hnonsec   = 1'b0;
    assign hmaster   = MASTER_ID;
    assign hexcl     = 1'b0;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rstn && accept) begin
            if ((cmd_size > 3'd2) ||
                ((cmd_size == 3'd1) && cmd_addr[0]) ||
                ((cmd_size == 3'd2) && (cmd_addr[1:0] != 2'b00)))
                $error("ahb_cmd_master: illegal command size=%0d addr=0x%0h", cmd_size, cmd_addr);
        end
    end
`endif

`ifdef AHB_MST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0]         wait_cnt_reg;
    logic                  timeout_reg;
    logic [ADDR_WIDTH-1:0] dp_addr_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
            dp_addr_reg  <= '0;
        end else begin
            if (ap_adv)
                dp_addr_reg <= ap_addr_reg;
            // Counts consecutive wait states of one data phase; flag is sticky
            if (dp_valid_reg && !hready) begin
                if (wait_cnt_reg != TW'(TIMEOUT_CYC))
                    wait_cnt_reg <= wait_cnt_reg + 1'b1;
                if (wait_cnt_reg == TW'(TIMEOUT_CYC - 1)) begin
                    timeout_reg <= 1'b1;
`ifndef SYNTHESIS
                    if (!timeout_reg)
                        $error("ahb_cmd_master: wait-state timeout, haddr=0x%0h", dp_addr_reg);
`endif
                end
            end else begin
                wait_cnt_reg <= '0;
            end
        end
    end

    assign timeout = timeout_reg;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Directed + randomized bench for ahb_cmd_master with a behavioural AHB responder
// and a byte-level reference memory evaluated in command order.
module tb_ahb_cmd_master;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [2:0]  cmd_size;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] haddr, hwdata, hrdata;
    logic        hwrite, hnonsec, hexcl, hready, hresp, hexokay, timeout;
    logic [2:0]  hsize, hburst;
    logic [1:0]  htrans;
    logic [6:0]  hprot;
    logic [3:0]  hmaster;

    ahb_cmd_master #(.TIMEOUT_CYC(8)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .htrans(htrans), .hwdata(hwdata), .hprot(hprot), .hnonsec(hnonsec),
        .hmaster(hmaster), .hexcl(hexcl), .hready(hready), .hresp(hresp),
        .hrdata(hrdata), .hexokay(hexokay), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        int          acc_cyc;
    } cmd_t;

    cmd_t send_q[$];
    cmd_t sb_q[$];
    int   acc_log[$];
    int   rsp_log[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // environment knobs
    int          fixed_wait = 0;
    logic [31:0] err_tgt    = 32'hFFFF_FFF0;
    logic [31:0] cancel_tgt = 32'hFFFF_FFF0;
    bit          lat_chk    = 1'b0;
    bit          gaps       = 1'b0;

    // responder state
    bit          dp_act = 1'b0;
    bit          dp_write, dp_err;
    logic [31:0] dp_addr;
    logic [2:0]  dp_size;
    int          wait_left = 0;
    logic [31:0] slv_mem [0:255];
    logic [7:0]  ref_mem [0:1023];

    // observation state
    bit          prev_ap_hold = 1'b0, prev_wd_hold = 1'b0;
    logic [31:0] prev_addr, prev_wdata;
    logic [3:0]  prev_ctl;
    int          nonseq_run = 0, nonseq_max = 0, hwdata_hold_cnt = 0, err2_cnt = 0;
    logic [31:0] hold_tag = 32'h0;

    function automatic logic [31:0] init_word(input int i);
        return 32'h5A5A_0000 ^ (32'(i) * 32'h0101_0307);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: commands take effect in acceptance order, evaluated when their response is due
    task automatic ref_eval(input cmd_t c, output logic [31:0] erd, output logic eerr);
        int base;
        int a;
        erd  = '0;
        eerr = 1'b0;
        if (c.addr == err_tgt || c.addr == cancel_tgt) begin
            eerr = 1'b1;
        end else if (c.write) begin
            for (int k = 0; k < (1 << c.size); k++) begin
                a = int'(c.addr[9:0]) + k;
                ref_mem[a] = c.wdata[8*(a%4) +: 8];
            end
        end else begin
            base = int'(c.addr[9:0]) & ~3;
            erd  = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
        end
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        cmd_t c;
        c.write = w; c.addr = a; c.size = s; c.wdata = d; c.acc_cyc = 0;
        send_q.push_back(c);
    endtask

    task automatic cycle();
        logic        acc, ap_go, s_hready, s_write, eerr;
        logic [31:0] s_addr, s_wdata, erd, w;
        logic [2:0]  s_size;
        int          lo, hi;
        cmd_t        c;
        @(negedge clk);
        cyc++;
        s_hready = hready;
        acc      = cmd_valid && cmd_ready;
        ap_go    = (htrans == 2'b10) && hready;
        s_addr = haddr; s_write = hwrite; s_size = hsize; s_wdata = hwdata;
        if (prev_ap_hold && htrans == 2'b10) begin
            chk("haddr_stable", haddr, prev_addr);
            chk("hctl_stable", 32'({hwrite, hsize}), 32'(prev_ctl));
        end
        if (prev_wd_hold) chk("hwdata_stable", hwdata, prev_wdata);
        prev_ap_hold = (htrans == 2'b10) && !hready;
        prev_addr = haddr; prev_ctl = {hwrite, hsize};
        prev_wd_hold = dp_act && dp_write && !hready;
        prev_wdata = hwdata;
        if (dp_act && dp_err && hready) begin
            err2_cnt++;
            chk("err2_htrans_idle", 32'(htrans), 32'd0);
            chk("err2_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        if (htrans == 2'b10) begin
            nonseq_run++;
            if (nonseq_run > nonseq_max) nonseq_max = nonseq_run;
        end else begin
            nonseq_run = 0;
        end
        if (dp_act && dp_write && hwdata === hold_tag) hwdata_hold_cnt++;
        if (rsp_valid) begin
            rsp_log.push_back(cyc);
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                c = sb_q.pop_front();
                ref_eval(c, erd, eerr);
                chk("rsp_rdata", rsp_rdata, erd);
                chk("rsp_err", 32'(rsp_err), 32'(eerr));
                if (lat_chk) chk("rsp_latency", 32'(cyc - c.acc_cyc), 32'd3);
            end
        end
        @(posedge clk);
        #1;
        if (dp_act) begin
            if (s_hready) begin
                if (dp_write && !dp_err) begin
                    w  = slv_mem[dp_addr[9:2]];
                    lo = int'(dp_addr[1:0]);
                    hi = lo + (1 << dp_size);
                    for (int l = 0; l < 4; l++)
                        if (l >= lo && l < hi) w[8*l +: 8] = s_wdata[8*l +: 8];
                    slv_mem[dp_addr[9:2]] = w;
                end
                dp_act = 1'b0;
            end else begin
                wait_left--;
            end
        end
        if (ap_go) begin
            dp_act = 1'b1; dp_addr = s_addr; dp_write = s_write; dp_size = s_size;
            dp_err = (s_addr == err_tgt);
            wait_left = dp_err ? 1 : (fixed_wait >= 0 ? fixed_wait : int'($urandom_range(2, 0)));
        end
        hready = !dp_act || (wait_left == 0);
        hresp  = dp_act && dp_err;
        hrdata = (dp_act && !dp_write && !dp_err && wait_left == 0) ? slv_mem[dp_addr[9:2]] : $urandom();
        if (acc && send_q.size() > 0) begin
            c = send_q.pop_front();
            c.acc_cyc = cyc;
            sb_q.push_back(c);
            acc_log.push_back(cyc);
        end
        if (send_q.size() > 0 && (!gaps || $urandom_range(3, 0) != 0)) begin
            cmd_valid = 1'b1;
            cmd_write = send_q[0].write; cmd_addr = send_q[0].addr;
            cmd_size  = send_q[0].size;  cmd_wdata = send_q[0].wdata;
        end else begin
            cmd_valid = 1'b0;
        end
    endtask

    task automatic drain(input int bound);
        int k;
        k = 0;
        while ((send_q.size() > 0 || sb_q.size() > 0) && k < bound) begin
            cycle();
            k++;
        end
        chk("drain_complete", 32'(send_q.size() + sb_q.size()), 32'd0);
        repeat (2) cycle();
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_htrans"}, 32'(htrans), 32'd0);
        chk({tag, "_haddr"}, haddr, 32'd0);
        chk({tag, "_hctl"}, 32'({hwrite, hsize, hburst}), 32'd0);
        chk({tag, "_hwdata"}, hwdata, 32'd0);
        chk({tag, "_hprot"}, 32'(hprot), 32'h3);
        chk({tag, "_hattr"}, 32'({hmaster, hexcl, hnonsec}), 32'd0);
        chk({tag, "_rsp"}, 32'({rsp_valid, rsp_err}), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, mask, w;
        logic [2:0]  s;
        int          k;
        for (int i = 0; i < 256; i++) slv_mem[i] = init_word(i);
        for (int b = 0; b < 1024; b++) begin
            w = init_word(b / 4);
            ref_mem[b] = w[8*(b%4) +: 8];
        end
        rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
        cmd_wdata = '0; hready = 1'b1; hresp = 1'b0; hrdata = '0; hexokay = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_checks("reset");
        rstn = 1'b1;
        repeat (3) cycle();

        // 1: write then read, zero wait states, latency 3
        lat_chk = 1'b1; fixed_wait = 0; acc_log.delete(); rsp_log.delete();
        send(1'b1, 32'h100, 3'd2, 32'hDEADBEEF);
        send(1'b0, 32'h100, 3'd2, 32'h0);
        drain(50);
        chk("t1_b2b_accept", 32'(acc_log[1] - acc_log[0]), 32'd1);

        // 2: four back-to-back reads
        nonseq_max = 0; rsp_log.delete();
        for (int i = 0; i < 4; i++) send(1'b0, 32'h100 + 32'(4 * i), 3'd2, 32'h0);
        drain(50);
        chk("t2_nonseq_run", 32'(nonseq_max), 32'd4);
        chk("t2_rsp_count", 32'(rsp_log.size()), 32'd4);
        chk("t2_rsp_consecutive", 32'(rsp_log[3] - rsp_log[0]), 32'd3);
        lat_chk = 1'b0;

        // 3: write with three wait states, read queued behind it
        fixed_wait = 3; hold_tag = 32'hCAFEF00D; hwdata_hold_cnt = 0;
        send(1'b1, 32'h104, 3'd2, 32'hCAFEF00D);
        send(1'b0, 32'h104, 3'd2, 32'h0);
        drain(50);
        chk("t3_hwdata_hold_cycles", 32'(hwdata_hold_cnt), 32'd4);

        // 4: ERROR on 0x200 with 0x204 pending in the address phase
        fixed_wait = 0; err_tgt = 32'h200; cancel_tgt = 32'h204; err2_cnt = 0;
        send(1'b0, 32'h200, 3'd2, 32'h0);
        send(1'b0, 32'h204, 3'd2, 32'h0);
        send(1'b0, 32'h100, 3'd2, 32'h0);
        drain(50);
        chk("t4_err2_cycles", 32'(err2_cnt), 32'd1);
        err_tgt = 32'hFFFF_FFF0; cancel_tgt = 32'hFFFF_FFF0;

        // 5: reset during a wait state drops the write
        fixed_wait = 6;
        send(1'b1, 32'h108, 3'd2, 32'h1111_2222);
        k = 0;
        while (!dp_act && k < 10) begin cycle(); k++; end
        chk("t5_reached_wait", 32'(dp_act), 32'd1);
        cycle();
        rstn = 1'b0;
        #1;
        reset_checks("t5_reset");
        repeat (3) begin
            @(negedge clk);
            chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
        end
        send_q.delete(); sb_q.delete();
        dp_act = 1'b0; hready = 1'b1; hresp = 1'b0; cmd_valid = 1'b0;
        prev_ap_hold = 1'b0; prev_wd_hold = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        fixed_wait = 0;
        send(1'b0, 32'h108, 3'd2, 32'h0);
        send(1'b1, 32'h10E, 3'd1, 32'hBEEF_0000);
        send(1'b0, 32'h10C, 3'd2, 32'h0);
        drain(50);

        // 6: long wait state against the timeout limit
        fixed_wait = 9;
        send(1'b1, 32'h110, 3'd2, 32'h0BAD_F00D);
        drain(60);
`ifdef AHB_MST_TIMEOUT_EN
        chk("t6_timeout_set", 32'(timeout), 32'd1);
        repeat (3) cycle();
        chk("t6_timeout_sticky", 32'(timeout), 32'd1);
`else
        chk("t6_timeout_tied_low", 32'(timeout), 32'd0);
`endif

        // randomized traffic with random waits and idle gaps
        fixed_wait = -1; gaps = 1'b1;
        for (int i = 0; i < 250; i++) begin
            s    = 3'($urandom_range(2, 0));
            mask = (32'd1 << s) - 32'd1;
            a    = 32'($urandom_range(1023, 0)) & ~mask;
            send(1'($urandom_range(1, 0)), a, s, $urandom());
        end
        drain(5000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
